mont_host_sequencer: RTL and testbench
======================================

Name: mont_host_sequencer

Overview:
- Hardware command initiator for the dual-core Montgomery wrapper; drives the far side of the port1/bram_din/bram_dout/port2 protocol that the ARM normally drives.
- On one start pulse it issues LOAD_A, LOAD_B, LOAD_M (each maskable), MULTIPLY and WRITE in that order, then returns both 512-bit results.
- Used for on-chip self-test and for ARM-less exponentiation loops.

Parameters:
- DATA_W, 512, width of each operand and result lane.
- CMD_W, 32, width of the port1 command word.
- TIMEOUT_CYCLES, 1048576, maximum cycles spent waiting on any single responder handshake. 0 disables the timeout.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- start  in  1  one-cycle request. Sampled only in IDLE.
- load_mask  in  3  bit0 = load A, bit1 = load B, bit2 = load M. Sampled with start.
- a1_in, a2_in, b1_in, b2_in, m1_in, m2_in  in  DATA_W  operands. Captured on accepted start.
- busy  out  1  high from the cycle after an accepted start until done or error.
- done  out  1  one-cycle pulse when results are valid.
- error  out  1  one-cycle pulse on timeout.
- res1_out, res2_out  out  DATA_W  captured results. Held until the next accepted start.
- port1_din  out  CMD_W  command word.
- port1_valid  out  1  command valid.
- port1_read  in  1  responder has taken the command.
- bram_din1, bram_din2  out  DATA_W  operand lanes.
- bram_din_valid  out  1  operand lanes valid.
- bram_dout1, bram_dout2  in  DATA_W  result lanes.
- bram_dout1_valid, bram_dout2_valid  in  1  result lanes valid.
- bram_dout_read  out  1  result-taken pulse.
- port2_valid  in  1  responder done.
- port2_read  out  1  done-acknowledge pulse.

Behaviour:
- Reset:
  - All outputs are 0; result registers are 0; state goes to IDLE.
  - Reset mid-sequence aborts immediately. No further handshake edges are produced.
- States: IDLE, CMD, DATA, RES, WAIT_DONE, ACK, CLR, NEXT.
- IDLE:
  - start=1 captures the operands and load_mask and selects the first step.
  - The step list is the enabled loads in A, B, M order, then MULTIPLY, then WRITE. MULTIPLY and WRITE always run.
  - Go to CMD. start is ignored while busy.
- CMD:
  - port1_valid=1 with port1_din = the step's command code, held stable.
  - On the cycle port1_read=1 is sampled: deassert port1_valid on the next cycle and branch:
    - load step -> DATA;
    - MULTIPLY -> WAIT_DONE;
    - WRITE -> RES.
  - port1_read arrives at least one cycle after port1_valid. No combinational path exists from port1_read to port1_valid.
- DATA:
  - bram_din1/2 = the selected operand pair; bram_din_valid=1.
  - Both are held until port2_valid=1 is sampled, then dropped and go to ACK.
  - bram_din lanes return to 0 whenever bram_din_valid=0.
- RES:
  - Wait until bram_dout1_valid and bram_dout2_valid are both 1.
  - Capture bram_dout1/2 into res1_out/res2_out and pulse bram_dout_read for exactly one cycle, then go to WAIT_DONE.
  - If the two valids are not simultaneous, keep waiting. Never pulse read twice per WRITE step.
- WAIT_DONE: wait for port2_valid=1, then go to ACK.
- ACK: port2_read=1 for exactly one cycle, then go to CLR.
- CLR:
  - Wait for port2_valid=0; the responder's port2_valid lags its state by one cycle.
  - This stale high level must not be treated as a second done. Then go to NEXT.
- NEXT:
  - Advance to the next step and go to CMD.
  - After WRITE: pulse done, clear busy, go to IDLE.
- Timeout:
  - A counter clears on every state change and counts in CMD, DATA, RES, WAIT_DONE and CLR.
  - When it reaches TIMEOUT_CYCLES: pulse error, drop all handshake outputs, clear busy, return to IDLE.
  - res*_out keep their old value; done is not pulsed.
- Latency per step, zero-wait responder: CMD 2 cycles, DATA 2 cycles, ACK 1, CLR 1, NEXT 1.
- Simultaneous events:
  - reset has priority over everything.
  - A timeout and a handshake completing in the same cycle: the handshake wins.
- Ordering constraint: port1_valid is never asserted while port2_valid is 1, so a new command never overlaps a pending done.

Decomposition:
- Package mont_cmd_pkg holds:
  - CMD_READ_A1_A2=0, CMD_READ_B1_B2=1, CMD_READ_M1_M2=2, CMD_MULTIPLY=3, CMD_WRITE=4;
  - the state encoding;
  - the step enumeration.
- The same package is imported by the Montgomery wrapper.
- Sub-module mont_handshake_timer: a loadable clear/enable/expire counter parameterised by TIMEOUT_CYCLES.

Test Plan:
- Full run, load_mask=3'b111, behavioural responder with fixed a/b/m, zero extra wait:
  - port1_din sequence is 0,1,2,3,4;
  - exactly 5 port2_read pulses;
  - res1_out/res2_out equal the model results;
  - done pulses once.
- load_mask=3'b100, after a prior full run: command sequence 2,3,4; A/B are not re-sent; results match with the old A/B.
- Responder delays port1_read 7 cycles and port2_valid 40 cycles: port1_valid is held stable for all 7 cycles; no duplicate port2_read pulses; done follows.
- Responder asserts bram_dout1_valid 3 cycles before bram_dout2_valid: capture happens only when both are high; a single bram_dout_read pulse.
- TIMEOUT_CYCLES=16, responder never asserts port2_valid after MULTIPLY: error pulses 16 cycles after WAIT_DONE entry; busy=0; done=0; res*_out unchanged.
- reset asserted for 1 cycle during DATA for B: the next cycle has all outputs at 0 and IDLE; a new start then runs the full 0..4 sequence correctly.

Source files
------------

// File: rtl/mont_cmd_pkg.sv
// rtl/mont_cmd_pkg.sv - command codes, sequencer states and step list shared with the Montgomery wrapper
package mont_cmd_pkg;

    localparam int CMD_READ_A1_A2 = 0;
    localparam int CMD_READ_B1_B2 = 1;
    localparam int CMD_READ_M1_M2 = 2;
    localparam int CMD_MULTIPLY   = 3;
    localparam int CMD_WRITE      = 4;

    typedef enum logic [2:0] {
        S_IDLE, S_CMD, S_DATA, S_RES, S_WAIT_DONE, S_ACK, S_CLR, S_NEXT
    } seq_state_t;

    typedef enum logic [2:0] {
        STEP_A, STEP_B, STEP_M, STEP_MUL, STEP_WR
    } step_t;

    function automatic step_t first_step(input logic [2:0] mask);
        if (mask[0]) return STEP_A;
        if (mask[1]) return STEP_B;
        if (mask[2]) return STEP_M;
        return STEP_MUL;
    endfunction

    // Skips disabled loads; MULTIPLY and WRITE always follow.
    function automatic step_t step_after(input step_t step, input logic [2:0] mask);
        case (step)
            STEP_A:  return mask[1] ? STEP_B : (mask[2] ? STEP_M : STEP_MUL);
            STEP_B:  return mask[2] ? STEP_M : STEP_MUL;
            STEP_M:  return STEP_MUL;
            default: return STEP_WR;
        endcase
    endfunction

    function automatic logic [2:0] step_cmd(input step_t step);
        case (step)
            STEP_A:   return 3'(CMD_READ_A1_A2);
            STEP_B:   return 3'(CMD_READ_B1_B2);
            STEP_M:   return 3'(CMD_READ_M1_M2);
            STEP_MUL: return 3'(CMD_MULTIPLY);
            default:  return 3'(CMD_WRITE);
        endcase
    endfunction

endpackage

// File: rtl/mont_handshake_timer.sv
// rtl/mont_handshake_timer.sv - clear/enable counter that flags a stalled responder handshake
module mont_handshake_timer #(
    parameter int TIMEOUT_CYCLES = 1048576
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic expire
);
    localparam int CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CW-1:0] LAST = CW'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);
    localparam bit ARMED = (TIMEOUT_CYCLES != 0);

    logic [CW-1:0] count;

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            count <= '0;
        end else if (enable && !expire) begin
            count <= count + CW'(1);
        end
    end

    // Fires on the last allowed waiting cycle so the exit happens exactly TIMEOUT_CYCLES after entry.
    assign expire = ARMED && enable && (count == LAST);

endmodule

// File: rtl/mont_host_sequencer.sv
// rtl/mont_host_sequencer.sv - hardware initiator driving load/multiply/write commands into the Montgomery wrapper
module mont_host_sequencer
    import mont_cmd_pkg::*;
#(
    parameter int DATA_W         = 512,
    parameter int CMD_W          = 32,
    parameter int TIMEOUT_CYCLES = 1048576
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [2:0]        load_mask,
    input  logic [DATA_W-1:0] a1_in,
    input  logic [DATA_W-1:0] a2_in,
    input  logic [DATA_W-1:0] b1_in,
    input  logic [DATA_W-1:0] b2_in,
    input  logic [DATA_W-1:0] m1_in,
    input  logic [DATA_W-1:0] m2_in,
    output logic              busy,
    output logic              done,
    output logic              error,
    output logic [DATA_W-1:0] res1_out,
    output logic [DATA_W-1:0] res2_out,
    output logic [CMD_W-1:0]  port1_din,
    output logic              port1_valid,
    input  logic              port1_read,
    output logic [DATA_W-1:0] bram_din1,
    output logic [DATA_W-1:0] bram_din2,
    output logic              bram_din_valid,
    input  logic [DATA_W-1:0] bram_dout1,
    input  logic [DATA_W-1:0] bram_dout2,
    input  logic              bram_dout1_valid,
    input  logic              bram_dout2_valid,
    output logic              bram_dout_read,
    input  logic              port2_valid,
    output logic              port2_read
);
    seq_state_t        state, state_d;
    step_t             step, step_d;
    logic [2:0]        mask;
    logic [DATA_W-1:0] a1, a2, b1, b2, m1, m2;
    logic              done_d, error_d, dout_read_d;
    logic              timer_en, expire;

    assign timer_en = state inside {S_CMD, S_DATA, S_RES, S_WAIT_DONE, S_CLR};

    mont_handshake_timer #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_timer (
        .clk    (clk),
        .reset  (reset),
        .clear  (state_d != state),
        .enable (timer_en),
        .expire (expire)
    );

    always_comb begin
        state_d     = state;
        step_d      = step;
        done_d      = 1'b0;
        error_d     = 1'b0;
        dout_read_d = 1'b0;
        case (state)
            S_IDLE: if (start) begin
                state_d = S_CMD;
                step_d  = first_step(load_mask);
            end
            S_CMD: if (port1_read) begin
                if (step == STEP_MUL)     state_d = S_WAIT_DONE;
                else if (step == STEP_WR) state_d = S_RES;
                else                      state_d = S_DATA;
            end
            S_DATA:      if (port2_valid) state_d = S_ACK;
            S_RES: if (bram_dout1_valid && bram_dout2_valid) begin
                state_d     = S_WAIT_DONE;
                dout_read_d = 1'b1;
            end
            S_WAIT_DONE: if (port2_valid) state_d = S_ACK;
            S_ACK:       state_d = S_CLR;
            // port2_valid trails the responder by a cycle; wait for it to fall before moving on.
            S_CLR:       if (!port2_valid) state_d = S_NEXT;
            S_NEXT: if (step == STEP_WR) begin
                state_d = S_IDLE;
                done_d  = 1'b1;
            end else begin
                state_d = S_CMD;
                step_d  = step_after(step, mask);
            end
            default:     state_d = S_IDLE;
        endcase
        // A handshake completing in the same cycle already moved state_d, so it beats the timeout.
        if (expire && state_d == state) begin
            state_d = S_IDLE;
            error_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state          <= S_IDLE;
            step           <= STEP_A;
            mask           <= '0;
            {a1, a2, b1, b2, m1, m2} <= '0;
            res1_out       <= '0;
            res2_out       <= '0;
            done           <= 1'b0;
            error          <= 1'b0;
            bram_dout_read <= 1'b0;
        end else begin
            state          <= state_d;
            step           <= step_d;
            done           <= done_d;
            error          <= error_d;
            bram_dout_read <= dout_read_d;
            if (state == S_IDLE && start) begin
                mask <= load_mask;
                {a1, a2, b1, b2, m1, m2} <= {a1_in, a2_in, b1_in, b2_in, m1_in, m2_in};
            end
            if (dout_read_d) begin
                res1_out <= bram_dout1;
                res2_out <= bram_dout2;
            end
        end
    end

    assign busy           = (state != S_IDLE);
    assign port1_valid    = (state == S_CMD);
    assign port1_din      = port1_valid ? CMD_W'(step_cmd(step)) : '0;
    assign bram_din_valid = (state == S_DATA);
    assign port2_read     = (state == S_ACK);

    always_comb begin
        bram_din1 = '0;
        bram_din2 = '0;
        if (bram_din_valid) begin
            case (step)
                STEP_A:  {bram_din1, bram_din2} = {a1, a2};
                STEP_B:  {bram_din1, bram_din2} = {b1, b2};
                default: {bram_din1, bram_din2} = {m1, m2};
            endcase
        end
    end

endmodule

// File: tb/tb_mont_host_sequencer.sv
// tb/tb_mont_host_sequencer.sv - directed vector bench with a behavioural Montgomery wrapper responder
module tb_mont_host_sequencer;
    localparam int DW = 512;
    localparam int TO = 48;

    logic          clk, reset, start;
    logic [2:0]    load_mask;
    logic [DW-1:0] a1_in, a2_in, b1_in, b2_in, m1_in, m2_in;
    logic          busy, done, error;
    logic [DW-1:0] res1_out, res2_out;
    logic [31:0]   port1_din;
    logic          port1_valid, port1_read;
    logic [DW-1:0] bram_din1, bram_din2, bram_dout1, bram_dout2;
    logic          bram_din_valid, bram_dout1_valid, bram_dout2_valid, bram_dout_read;
    logic          port2_valid, port2_read;

    mont_host_sequencer #(.DATA_W(DW), .CMD_W(32), .TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .reset(reset), .start(start), .load_mask(load_mask),
        .a1_in(a1_in), .a2_in(a2_in), .b1_in(b1_in), .b2_in(b2_in), .m1_in(m1_in), .m2_in(m2_in),
        .busy(busy), .done(done), .error(error), .res1_out(res1_out), .res2_out(res2_out),
        .port1_din(port1_din), .port1_valid(port1_valid), .port1_read(port1_read),
        .bram_din1(bram_din1), .bram_din2(bram_din2), .bram_din_valid(bram_din_valid),
        .bram_dout1(bram_dout1), .bram_dout2(bram_dout2),
        .bram_dout1_valid(bram_dout1_valid), .bram_dout2_valid(bram_dout2_valid),
        .bram_dout_read(bram_dout_read), .port2_valid(port2_valid), .port2_read(port2_read)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic [2:0]    mask;
        logic [DW-1:0] a1, a2, b1, b2, m1, m2;
        int            p1_delay, mul_delay, d2_delay;
        bit            restart;
        logic [31:0]   exp_seq;
        int            exp_steps;
        logic [DW-1:0] exp_r1, exp_r2;
    } vec_t;

    vec_t vecs[4];
    int   n_chk = 0, n_pass = 0;

    // Responder knobs and observations
    int            p1_delay = 1, mul_delay = 1, d2_delay = 0;
    bit            never_done = 0;
    int            p1_cnt = 0, d_cnt = 0, done_cnt = -1, w_cnt = -1, cyc = 0;
    logic [2:0]    pend = 3'd0;
    logic [DW-1:0] ra1 = '0, ra2 = '0, rb1 = '0, rb2 = '0, rm1 = '0, rm2 = '0, r1m = '0, r2m = '0;
    logic [31:0]   seq_log, p1_first;
    int            seq_n, p2r_seen, dread_seen, done_seen, err_seen;
    int            unstable, overlap, lane_err, mul_cyc, err_cyc;

    task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // Behavioural wrapper: registered-style replies, sampled and driven on the falling edge.
    initial begin : responder
        port1_read = 0; port2_valid = 0; bram_dout1_valid = 0; bram_dout2_valid = 0;
        bram_dout1 = '0; bram_dout2 = '0;
        forever begin
            @(negedge clk);
            cyc++;
            if (reset) begin
                port1_read = 0; port2_valid = 0; bram_dout1_valid = 0; bram_dout2_valid = 0;
                p1_cnt = 0; d_cnt = 0; done_cnt = -1; w_cnt = -1;
            end else begin
                if (done) done_seen++;
                if (error) begin err_seen++; err_cyc = cyc; end
                if (port1_valid && port2_valid) overlap++;
                if (!bram_din_valid && (bram_din1 != '0 || bram_din2 != '0)) lane_err++;
                if (done_cnt > 0) done_cnt--;
                else if (done_cnt == 0) begin port2_valid = 1; done_cnt = -1; end
                if (w_cnt >= 0) begin
                    if (w_cnt == 0) begin bram_dout1 = r1m; bram_dout1_valid = 1; end
                    if (w_cnt == d2_delay) begin bram_dout2 = r2m; bram_dout2_valid = 1; end
                    w_cnt++;
                end
                if (bram_din_valid) begin
                    if (d_cnt == 0) begin
                        case (pend)
                            3'd0:    begin ra1 = bram_din1; ra2 = bram_din2; end
                            3'd1:    begin rb1 = bram_din1; rb2 = bram_din2; end
                            default: begin rm1 = bram_din1; rm2 = bram_din2; end
                        endcase
                    end
                    if (d_cnt == 1) port2_valid = 1;
                    d_cnt++;
                end else d_cnt = 0;
                if (port2_read) begin p2r_seen++; port2_valid = 0; end
                if (bram_dout_read) begin
                    dread_seen++;
                    bram_dout1_valid = 0; bram_dout2_valid = 0; w_cnt = -1; done_cnt = 1;
                end
                if (port1_read) begin
                    port1_read = 0; p1_cnt = 0;
                end else if (port1_valid) begin
                    if (p1_cnt == 0) p1_first = port1_din;
                    else if (port1_din != p1_first) unstable++;
                    if (p1_cnt == p1_delay) begin
                        port1_read = 1;
                        seq_log = (seq_log << 4) | port1_din;
                        seq_n++;
                        case (port1_din)
                            32'd0, 32'd1, 32'd2: pend = port1_din[2:0];
                            32'd3: begin
                                r1m = ra1 + rb1 + rm1;
                                r2m = (ra2 ^ rb2) + rm2;
                                mul_cyc = cyc;
                                if (!never_done) done_cnt = mul_delay;
                            end
                            32'd4: begin w_cnt = 0; bram_dout1 = ~r1m; bram_dout2 = ~r2m; end
                            default: ;
                        endcase
                    end
                    p1_cnt++;
                end else p1_cnt = 0;
            end
        end
    end

    task automatic clear_obs();
        seq_log = 0; seq_n = 0; p2r_seen = 0; dread_seen = 0; done_seen = 0; err_seen = 0;
        unstable = 0; overlap = 0; lane_err = 0;
    endtask

    task automatic start_vec(input vec_t v);
        load_mask = v.mask;
        {a1_in, a2_in, b1_in, b2_in, m1_in, m2_in} = {v.a1, v.a2, v.b1, v.b2, v.m1, v.m2};
        p1_delay = v.p1_delay; mul_delay = v.mul_delay; d2_delay = v.d2_delay;
        clear_obs();
        @(negedge clk); start = 1;
        @(negedge clk); start = 0;
    endtask

    task automatic finish_vec(input vec_t v, input string tag);
        if (v.restart) begin
            repeat (5) @(negedge clk);
            load_mask = 3'b000; a1_in = '1; start = 1;
            @(negedge clk); start = 0;
        end
        for (int i = 0; i < 3000 && done_seen == 0 && err_seen == 0; i++) @(negedge clk);
        chk({tag, "_done_reached"}, DW'(done_seen), DW'(1));
        chk({tag, "_busy_at_done"}, DW'(busy), DW'(0));
        repeat (4) @(negedge clk);
        chk({tag, "_cmd_seq"}, DW'(seq_log), DW'(v.exp_seq));
        chk({tag, "_port2_read_pulses"}, DW'(p2r_seen), DW'(v.exp_steps));
        chk({tag, "_dout_read_pulses"}, DW'(dread_seen), DW'(1));
        chk({tag, "_res1"}, res1_out, v.exp_r1);
        chk({tag, "_res2"}, res2_out, v.exp_r2);
        chk({tag, "_done_once_no_error"}, DW'({done_seen, err_seen}), DW'({32'd1, 32'd0}));
        chk({tag, "_protocol"}, DW'({unstable, overlap, lane_err}), DW'(0));
    endtask

    initial begin
        vecs[0] = '{3'b111, 512'h100, 512'hF0, 512'h20, 512'h0F, {4'h8, 508'h3}, {4'h4, 508'h1},
                    1, 1, 0, 1'b0, 32'h01234, 5, {4'h8, 508'h123}, {4'h4, 508'h100}};
        vecs[1] = '{3'b100, 512'hDEAD, 512'hBEEF, 512'h1234, 512'h5678, 512'h5, 512'h7,
                    1, 1, 0, 1'b0, 32'h234, 3, 512'h125, 512'h106};
        vecs[2] = '{3'b111, 512'h3, 512'hAA, 512'h4, 512'h55, 512'h5, {4'hF, 508'h0},
                    7, 40, 0, 1'b1, 32'h01234, 5, 512'hC, {4'hF, 508'hFF}};
        vecs[3] = '{3'b010, 512'h999, 512'h999, 512'h10, 512'h0F, 512'h777, 512'h777,
                    1, 1, 3, 1'b0, 32'h134, 3, 512'h18, {4'hF, 508'hA5}};

        reset = 1; start = 0; load_mask = 0;
        {a1_in, a2_in, b1_in, b2_in, m1_in, m2_in} = '0;
        clear_obs();
        repeat (3) @(negedge clk);
        reset = 0;
        chk("reset_flags", DW'({busy, done, error, port1_valid, bram_din_valid, bram_dout_read, port2_read}), DW'(0));
        chk("reset_results", res1_out | res2_out | DW'(port1_din), DW'(0));

        for (int i = 0; i < 4; i++) begin
            start_vec(vecs[i]);
            chk($sformatf("v%0d_busy_after_start", i), DW'(busy), DW'(1));
            finish_vec(vecs[i], $sformatf("v%0d", i));
        end

        // Multiply never completes: the wait in WAIT_DONE must time out.
        never_done = 1;
        load_mask = 3'b000;
        clear_obs();
        @(negedge clk); start = 1;
        @(negedge clk); start = 0;
        for (int i = 0; i < 500 && err_seen == 0; i++) @(negedge clk);
        chk("to_latency", DW'(err_cyc - mul_cyc), DW'(TO + 1));
        chk("to_busy", DW'(busy), DW'(0));
        repeat (3) @(negedge clk);
        chk("to_error_once_no_done", DW'({err_seen, done_seen}), DW'({32'd1, 32'd0}));
        chk("to_outputs_dropped", DW'({port1_valid, bram_din_valid, port2_read, bram_dout_read}), DW'(0));
        chk("to_res1_kept", res1_out, vecs[3].exp_r1);
        chk("to_res2_kept", res2_out, vecs[3].exp_r2);
        never_done = 0;

        // Reset in the middle of the B operand transfer.
        start_vec(vecs[0]);
        for (int i = 0; i < 200 && !(seq_n == 2 && bram_din_valid); i++) @(negedge clk);
        chk("rst_in_data_b", DW'({seq_log, bram_din_valid}), DW'({32'h01, 1'b1}));
        @(posedge clk); #1 reset = 1;
        @(posedge clk); #1 reset = 0;
        @(negedge clk);
        chk("rst_mid_flags", DW'({busy, done, error, port1_valid, bram_din_valid, bram_dout_read, port2_read}), DW'(0));
        chk("rst_mid_values", res1_out | res2_out | bram_din1 | bram_din2 | DW'(port1_din), DW'(0));
        repeat (2) @(negedge clk);
        start_vec(vecs[0]);
        finish_vec(vecs[0], "rerun");

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
